// File: rtl/axi_riscv_amo_initiator_if.sv
// Core-side request/response port plus the five AXI master channels of
// axi_riscv_amo_initiator. The "master" modport is the initiator's view,
// the "slave" modport is the view of the core and memory around it.
interface axi_riscv_amo_initiator_if #(
    parameter int unsigned AXI_ADDR_WIDTH   = 64,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_ID_WIDTH     = 5,
    parameter int unsigned RISCV_WORD_WIDTH = 64
) ();
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [3:0]                    req_op_i;
    logic [AXI_ADDR_WIDTH-1:0]     req_addr_i;
    logic [1:0]                    req_size_i;
    logic [RISCV_WORD_WIDTH-1:0]   req_wdata_i;

    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [RISCV_WORD_WIDTH-1:0]   rsp_rdata_o;
    logic                          rsp_err_o;

    logic [AXI_ADDR_WIDTH-1:0]     mst_aw_addr_o;
    logic [2:0]                    mst_aw_size_o;
    logic [5:0]                    mst_aw_atop_o;
    logic                          mst_aw_lock_o;
    logic [AXI_ID_WIDTH-1:0]       mst_aw_id_o;
    logic [7:0]                    mst_aw_len_o;
    logic [1:0]                    mst_aw_burst_o;
    logic                          mst_aw_valid_o;
    logic                          mst_aw_ready_i;

    logic [AXI_DATA_WIDTH-1:0]     mst_w_data_o;
    logic [AXI_DATA_WIDTH/8-1:0]   mst_w_strb_o;
    logic                          mst_w_last_o;
    logic                          mst_w_valid_o;
    logic                          mst_w_ready_i;

    logic [1:0]                    mst_b_resp_i;
    logic [AXI_ID_WIDTH-1:0]       mst_b_id_i;
    logic                          mst_b_valid_i;
    logic                          mst_b_ready_o;

    logic [AXI_ADDR_WIDTH-1:0]     mst_ar_addr_o;
    logic [2:0]                    mst_ar_size_o;
    logic                          mst_ar_lock_o;
    logic [AXI_ID_WIDTH-1:0]       mst_ar_id_o;
    logic [7:0]                    mst_ar_len_o;
    logic [1:0]                    mst_ar_burst_o;
    logic                          mst_ar_valid_o;
    logic                          mst_ar_ready_i;

    logic [AXI_DATA_WIDTH-1:0]     mst_r_data_i;
    logic [1:0]                    mst_r_resp_i;
    logic                          mst_r_last_i;
    logic [AXI_ID_WIDTH-1:0]       mst_r_id_i;
    logic                          mst_r_valid_i;
    logic                          mst_r_ready_o;

    modport master (
        input  req_valid_i, req_op_i, req_addr_i, req_size_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output mst_aw_addr_o, mst_aw_size_o, mst_aw_atop_o, mst_aw_lock_o,
               mst_aw_id_o, mst_aw_len_o, mst_aw_burst_o, mst_aw_valid_o,
        input  mst_aw_ready_i,
        output mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_valid_o,
        input  mst_w_ready_i,
        input  mst_b_resp_i, mst_b_id_i, mst_b_valid_i,
        output mst_b_ready_o,
        output mst_ar_addr_o, mst_ar_size_o, mst_ar_lock_o, mst_ar_id_o,
               mst_ar_len_o, mst_ar_burst_o, mst_ar_valid_o,
        input  mst_ar_ready_i,
        input  mst_r_data_i, mst_r_resp_i, mst_r_last_i, mst_r_id_i, mst_r_valid_i,
        output mst_r_ready_o
    );

    modport slave (
        output req_valid_i, req_op_i, req_addr_i, req_size_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  mst_aw_addr_o, mst_aw_size_o, mst_aw_atop_o, mst_aw_lock_o,
               mst_aw_id_o, mst_aw_len_o, mst_aw_burst_o, mst_aw_valid_o,
        output mst_aw_ready_i,
        input  mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_valid_o,
        output mst_w_ready_i,
        output mst_b_resp_i, mst_b_id_i, mst_b_valid_i,
        input  mst_b_ready_o,
        input  mst_ar_addr_o, mst_ar_size_o, mst_ar_lock_o, mst_ar_id_o,
               mst_ar_len_o, mst_ar_burst_o, mst_ar_valid_o,
        output mst_ar_ready_i,
        output mst_r_data_i, mst_r_resp_i, mst_r_last_i, mst_r_id_i, mst_r_valid_i,
        input  mst_r_ready_o
    );
endinterface

// File: rtl/axi_riscv_amo_initiator.sv
// axi_riscv_amo_initiator: turns one RISC-V LR/SC/AMO request at a time into
// AXI transactions (AMOs as one-beat ATOP writes, LR/SC as exclusive accesses).
// Optional feature macro: AXI_AMO_INIT_LRSC_EN enables LR/SC; without it ops
// 0 and 1 are rejected as illegal and the lock outputs stay 0.
module axi_riscv_amo_initiator #(
    parameter int unsigned AXI_ADDR_WIDTH   = 64,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_ID_WIDTH     = 5,
    parameter int unsigned MST_ID           = 0,
    parameter int unsigned RISCV_WORD_WIDTH = 64
) (
    input logic                        clk_i,
    input logic                        rst_i,
    axi_riscv_amo_initiator_if.master  bus
);
    localparam int unsigned OFF_W  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, WAIT, RSP} state_t;
    state_t state_q, state_d;

    logic [3:0]                  op_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]                  size_q;
    logic [RISCV_WORD_WIDTH-1:0] wdata_q, rdata_q;
    logic err_q, aw_done_q, w_done_q, need_r_q, need_b_q;

    logic in_lr, in_sc, in_amo, in_illegal, size_ok, align_ok;
    logic q_lr, q_sc;
    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
    logic aw_valid, w_valid, ar_valid;
    logic [OFF_W-1:0]          lane;
    logic [63:0]               opnd, r_ext;
    logic [AXI_DATA_WIDTH-1:0] w_base, w_data, r_shift;
    logic [STRB_W-1:0]         strb_base, w_strb;
    logic                      unused_inputs;

    function automatic logic [5:0] atop_of(input logic [3:0] op);
        case (op)
            4'd2:    atop_of = 6'b110000;
            4'd3:    atop_of = 6'b100000;
            4'd4:    atop_of = 6'b100001;
            4'd5:    atop_of = 6'b100011;
            4'd6:    atop_of = 6'b100010;
            4'd7:    atop_of = 6'b100100;
            4'd8:    atop_of = 6'b100110;
            4'd9:    atop_of = 6'b100101;
            4'd10:   atop_of = 6'b100111;
            default: atop_of = 6'b000000;
        endcase
    endfunction

`ifdef AXI_AMO_INIT_LRSC_EN
    assign q_lr = (op_q == 4'd0);
    assign q_sc = (op_q == 4'd1);
`else
    assign q_lr = 1'b0;
    assign q_sc = 1'b0;
`endif

    // Classify the incoming request and decide whether it is legal
    always_comb begin
        in_lr = 1'b0;
        in_sc = 1'b0;
`ifdef AXI_AMO_INIT_LRSC_EN
        in_lr = (bus.req_op_i == 4'd0);
        in_sc = (bus.req_op_i == 4'd1);
`endif
        in_amo     = (bus.req_op_i >= 4'd2) && (bus.req_op_i <= 4'd10);
        size_ok    = (bus.req_size_i == 2'd3) ? (RISCV_WORD_WIDTH == 64) : (bus.req_size_i == 2'd2);
        align_ok   = (bus.req_size_i == 2'd3) ? (bus.req_addr_i[2:0] == 3'd0) : (bus.req_addr_i[1:0] == 2'd0);
        in_illegal = !(in_lr || in_sc || in_amo) || !size_ok || !align_ok;
    end

    assign aw_valid = (state_q == ISSUE_W) && !aw_done_q;
    assign w_valid  = (state_q == ISSUE_W) && !w_done_q;
    assign ar_valid = (state_q == ISSUE_R);
    assign aw_hs = aw_valid && bus.mst_aw_ready_i;
    assign w_hs  = w_valid && bus.mst_w_ready_i;
    assign ar_hs = ar_valid && bus.mst_ar_ready_i;
    assign r_hs  = bus.mst_r_ready_o && bus.mst_r_valid_i;
    assign b_hs  = bus.mst_b_ready_o && bus.mst_b_valid_i;
    assign lane  = addr_q[OFF_W-1:0];

    // Place the operand on its byte lane for W and pull the old value out of R
    always_comb begin
        opnd = '0;
        opnd[RISCV_WORD_WIDTH-1:0] = wdata_q;
        if (op_q == 4'd4) opnd = ~opnd;
        if (size_q == 2'd2) opnd[63:32] = '0;
        w_base = '0;
        w_base[63:0] = opnd;
        w_data = w_base << {lane, 3'b000};
        strb_base = '0;
        if (size_q == 2'd3) strb_base[7:0] = 8'hFF;
        else                strb_base[3:0] = 4'hF;
        w_strb  = strb_base << lane;
        r_shift = bus.mst_r_data_i >> {lane, 3'b000};
        if (size_q == 2'd2) r_ext = {{32{r_shift[31]}}, r_shift[31:0]};
        else                r_ext = r_shift[63:0];
    end

    // State register; reset abandons any outstanding bus transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid_i) state_d = in_illegal ? RSP : (in_lr ? ISSUE_R : ISSUE_W);
            ISSUE_W: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT;
            ISSUE_R: if (ar_hs) state_d = WAIT;
            WAIT:    if ((!need_r_q || r_hs) && (!need_b_q || b_hs)) state_d = RSP;
            RSP:     if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, handshake bookkeeping and response accumulation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q <= '0; addr_q <= '0; size_q <= '0; wdata_q <= '0; rdata_q <= '0;
            err_q <= 1'b0; aw_done_q <= 1'b0; w_done_q <= 1'b0;
            need_r_q <= 1'b0; need_b_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid_i) begin
                    op_q      <= bus.req_op_i;
                    addr_q    <= bus.req_addr_i;
                    size_q    <= bus.req_size_i;
                    wdata_q   <= bus.req_wdata_i;
                    rdata_q   <= '0;
                    err_q     <= in_illegal;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    need_r_q  <= !in_illegal && (in_lr || in_amo);
                    need_b_q  <= !in_illegal && (in_sc || in_amo);
                end
                ISSUE_W: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                WAIT: begin
                    if (r_hs) begin
                        need_r_q <= 1'b0;
                        rdata_q  <= r_ext[RISCV_WORD_WIDTH-1:0];
                        if (bus.mst_r_resp_i[1]) err_q <= 1'b1;
                    end
                    if (b_hs) begin
                        need_b_q <= 1'b0;
                        if (bus.mst_b_resp_i[1]) err_q <= 1'b1;
                        if (q_sc) rdata_q <= (bus.mst_b_resp_i == 2'b01) ? '0 : RISCV_WORD_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o    = (state_q == IDLE) && !rst_i;
    assign bus.rsp_valid_o    = (state_q == RSP);
    assign bus.rsp_rdata_o    = (state_q == RSP) ? rdata_q : '0;
    assign bus.rsp_err_o      = (state_q == RSP) && err_q;

    assign bus.mst_aw_valid_o = aw_valid;
    assign bus.mst_aw_addr_o  = aw_valid ? addr_q : '0;
    assign bus.mst_aw_size_o  = aw_valid ? {1'b0, size_q} : 3'd0;
    assign bus.mst_aw_atop_o  = aw_valid ? atop_of(op_q) : 6'd0;
    assign bus.mst_aw_lock_o  = aw_valid && q_sc;
    assign bus.mst_aw_id_o    = aw_valid ? AXI_ID_WIDTH'(MST_ID) : '0;
    assign bus.mst_aw_len_o   = 8'd0;
    assign bus.mst_aw_burst_o = aw_valid ? 2'b01 : 2'b00;

    assign bus.mst_w_valid_o  = w_valid;
    assign bus.mst_w_data_o   = w_valid ? w_data : '0;
    assign bus.mst_w_strb_o   = w_valid ? w_strb : '0;
    assign bus.mst_w_last_o   = w_valid;

    assign bus.mst_ar_valid_o = ar_valid;
    assign bus.mst_ar_addr_o  = ar_valid ? addr_q : '0;
    assign bus.mst_ar_size_o  = ar_valid ? {1'b0, size_q} : 3'd0;
    assign bus.mst_ar_lock_o  = ar_valid && q_lr;
    assign bus.mst_ar_id_o    = ar_valid ? AXI_ID_WIDTH'(MST_ID) : '0;
    assign bus.mst_ar_len_o   = 8'd0;
    assign bus.mst_ar_burst_o = ar_valid ? 2'b01 : 2'b00;

    assign bus.mst_b_ready_o  = (state_q == WAIT) && need_b_q;
    assign bus.mst_r_ready_o  = (state_q == WAIT) && need_r_q;

    // IDs, r_last and the EXOKAY bit of R are deliberately ignored
    assign unused_inputs = ^{bus.mst_b_id_i, bus.mst_r_id_i, bus.mst_r_last_i, bus.mst_r_resp_i[0]};
endmodule
